ltsm_sb_tx_arbiter: RTL and testbench
=====================================

# ltsm_sb_tx_arbiter

Shares the single sideband TX message channel between the LTSM state modules (RESET, SBINIT, MBINIT, MBTRAIN, LINKINIT, ACTIVE, …), each of which produces `SB_msg_t` requests. It sits between the per-state `TX_msg_o`/`TX_msg_valid_o` outputs and the sideband transmitter's `TX_msg_valid_ack_i` handshake. It grants one requester at a time in round-robin order, latches the granted message, holds it valid until the transmitter acknowledges, and then returns a one-cycle acknowledge to the winning requester.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ACK_TIMEOUT`, default 100000: cycles allowed for a transmitter acknowledge (1 ms at 100 MHz). Used only with the timeout feature.
- `clk_100MHz`  in  1  sideband clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  per-requester message-valid; held high until the matching `req_ack_o`.
- `req_msg_i`  in  NUM_REQ x SB_msg_t  per-requester message.
- `req_ack_o`  out  NUM_REQ  one-cycle acknowledge to the granted requester.
- `grant_o`  out  NUM_REQ  one-hot current grant; all-zero when idle.
- `TX_msg_o`  out  SB_msg_t  latched message to the sideband transmitter.
- `TX_msg_valid_o`  out  1  message valid to the transmitter.
- `TX_msg_valid_ack_i`  in  1  transmitter has accepted `TX_msg_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `timeout_err_o`  out  1  sticky acknowledge-timeout flag; only with the timeout feature, otherwise tied to 0.

## Operation
- FSM with three states: IDLE, SEND, ACK.
- IDLE: if any `req_valid_i` bit is set, select the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ. Latch `req_msg_i[sel]` into `TX_msg_o` and set `grant_o` to one-hot `sel`, then go to SEND.
- SEND: `TX_msg_valid_o`=1 and `TX_msg_o` stays stable. When `TX_msg_valid_ack_i`=1, go to ACK.
- ACK: `req_ack_o[sel]`=1 for this one cycle and `TX_msg_valid_o`=0. Set `rr_ptr` to (sel+1) mod NUM_REQ, clear `grant_o`, and return to IDLE.
- The message is captured once, at grant time. A requester that drops `req_valid_i` or changes its message while granted does not abort or alter the transfer; the ack is still pulsed.
- A `TX_msg_valid_ack_i` pulse outside SEND is ignored.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins. The others are served in order on later grants, so no requester starves.
- Reset values: state IDLE, `rr_ptr`=0, `TX_msg_o`='0, all outputs 0. Reset asserted mid-transfer drops the transfer immediately; no ack is issued.

## Timing
- A request sampled high at edge k (state IDLE) gives `grant_o` and `TX_msg_valid_o` high after edge k+1.
- An ack sampled at edge m gives `TX_msg_valid_o` low and `req_ack_o` high after edge m+1; `req_ack_o` drops after edge m+2.
- The earliest next grant is at edge m+3.
- Minimum cost per message: 3 cycles plus the transmitter acknowledge latency.

## Configuration
- `LTSM_SB_ARB_TIMEOUT_EN` defined:
  - A `$clog2(ACK_TIMEOUT+1)`-bit counter clears on entry to SEND and increments each SEND cycle.
  - When the counter reaches ACK_TIMEOUT without an acknowledge, set `timeout_err_o` and go to IDLE without pulsing `req_ack_o`. `rr_ptr` still advances.
  - `timeout_err_o` clears only on reset.
- `LTSM_SB_ARB_TIMEOUT_EN` undefined: no counter; SEND waits indefinitely; `timeout_err_o`=0.

## Structure
- `SB_msg_t` comes from `SB_codex_pkg`.
- The FSM state enum `ltsm_sb_arb_state_t` is added to the same package.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot grant and binary index.

## Test plan
- Single request on requester 2, with the transmitter acking 3 cycles after valid: `TX_msg_o` equals `req_msg_i[2]`, valid is high for 3 cycles, `req_ack_o`=4'b0100 pulses once, and `rr_ptr` becomes 3.
- All four requesting continuously from reset: grants follow the order 0,1,2,3,0; each requester receives exactly one ack per round.
- Requester 1 changes its message and drops valid one cycle after grant: the originally latched message is transmitted and `req_ack_o[1]` still pulses.
- Assert `reset` low during SEND: all outputs are 0 within the same cycle and there is no ack; after release, the pending request is regranted starting from index 0.
- Macro defined with ACK_TIMEOUT=10 and no transmitter ack: after 10 SEND cycles `timeout_err_o`=1, valid drops, and there is no `req_ack_o`; the next requester is then granted normally.
- Spurious `TX_msg_valid_ack_i` while IDLE: no state change and no ack output.

Source files
------------

// File: rtl/SB_codex_pkg.sv
// ----------------------------------------------------------------------------
// SB_codex_pkg
// Shared sideband types for the LTSM state modules and the sideband TX path.
//   SB_msg_t             : one sideband message request as produced by a state
//   ltsm_sb_arb_state_t  : state encoding of the sideband TX arbiter
//   rr_next()            : round-robin pointer advance (index after sel, wrapping)
// ----------------------------------------------------------------------------
package SB_codex_pkg;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [7:0]  msg_code;
        logic [7:0]  msg_subcode;
        logic [15:0] msg_info;
    } SB_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_ACK  = 2'd2
    } ltsm_sb_arb_state_t;

    // Index that follows sel in an n-entry ring.
    function automatic int unsigned rr_next(input int unsigned sel, input int unsigned n);
        return (sel + 1 >= n) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/ltsm_sb_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: picks the first set request bit at or
// after ptr, wrapping modulo N.
//   req   in  N      request vector
//   ptr   in  PTR_W  index with highest priority this round
//   grant out N      one-hot winner (all-zero when no request)
//   idx   out PTR_W  binary index of the winner (0 when no request)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    // cand[k] is the requester examined k-th in priority order this round.
    logic [PTR_W-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = PTR_W'((int'(ptr) + gi) % N);
        end
    endgenerate

    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand[k]]) begin
                found           = 1'b1;
                idx             = cand[k];
                grant[cand[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ltsm_sb_tx_arbiter.sv
// ----------------------------------------------------------------------------
// ltsm_sb_tx_arbiter
// Shares the single sideband TX message channel between the LTSM state
// modules. One requester is granted at a time in round-robin order; its
// message is latched at grant time, held valid until the transmitter
// acknowledges, and a one-cycle ack is then returned to the winner.
//
// Ports
//   clk_100MHz          in   sideband clock (rising edge)
//   reset               in   asynchronous active-low reset
//   req_valid_i         in   per-requester message valid (held until ack)
//   req_msg_i           in   per-requester message
//   req_ack_o           out  one-cycle ack to the granted requester
//   grant_o             out  one-hot current grant, zero when idle
//   TX_msg_o            out  latched message to the transmitter
//   TX_msg_valid_o      out  message valid to the transmitter
//   TX_msg_valid_ack_i  in   transmitter accepted TX_msg_o
//   busy_o              out  high whenever not idle
//   timeout_err_o       out  sticky ack-timeout flag
//
// Build option
//   LTSM_SB_ARB_TIMEOUT_EN : when defined, a transfer that is not acked within
//   ACK_TIMEOUT cycles is abandoned (no req_ack_o) and timeout_err_o is set.
//   When undefined, SEND waits indefinitely and timeout_err_o is 0.
// ----------------------------------------------------------------------------
module ltsm_sb_tx_arbiter
    import SB_codex_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 100000
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  SB_msg_t [NUM_REQ-1:0]   req_msg_i,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [NUM_REQ-1:0]      grant_o,
    output SB_msg_t                 TX_msg_o,
    output logic                    TX_msg_valid_o,
    input  logic                    TX_msg_valid_ack_i,
    output logic                    busy_o,
    output logic                    timeout_err_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ltsm_sb_arb_state_t   state_reg,  state_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]     sel_reg,    sel_next;
    logic [NUM_REQ-1:0]   grant_reg,  grant_next;
    SB_msg_t              tx_msg_reg, tx_msg_next;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [PTR_W-1:0]     pick_idx;
    logic                 timeout_hit;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req_valid_i),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

`ifdef LTSM_SB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_err_reg;

    // The counter sits at zero outside SEND, so it is zero on every entry.
    // The increment that would reach ACK_TIMEOUT is the expiry point, which
    // gives exactly ACK_TIMEOUT cycles of TX_msg_valid_o.
    assign timeout_hit = (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ARB_SEND) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                cnt_reg <= '0;
            end
            if (state_reg == ARB_SEND && !TX_msg_valid_ack_i && timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_reg;
`else
    logic unused_cfg;
    assign unused_cfg    = (ACK_TIMEOUT == 0);
    assign timeout_hit   = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_reg  <= ARB_IDLE;
            rr_ptr_reg <= '0;
            sel_reg    <= '0;
            grant_reg  <= '0;
            tx_msg_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            sel_reg    <= sel_next;
            grant_reg  <= grant_next;
            tx_msg_reg <= tx_msg_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        sel_next    = sel_reg;
        grant_next  = grant_reg;
        tx_msg_next = tx_msg_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (|req_valid_i) begin
                    sel_next    = pick_idx;
                    grant_next  = pick_grant;
                    // Captured once; later changes by the requester are ignored.
                    tx_msg_next = req_msg_i[pick_idx];
                    state_next  = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (TX_msg_valid_ack_i) begin
                    state_next = ARB_ACK;
                end else if (timeout_hit) begin
                    // Abandoned transfer still advances the pointer so the
                    // stuck requester does not block the others.
                    rr_ptr_next = PTR_W'(rr_next(32'(sel_reg), 32'(NUM_REQ)));
                    grant_next  = '0;
                    state_next  = ARB_IDLE;
                end
            end
            ARB_ACK: begin
                rr_ptr_next = PTR_W'(rr_next(32'(sel_reg), 32'(NUM_REQ)));
                grant_next  = '0;
                state_next  = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign grant_o        = grant_reg;
    assign TX_msg_o       = tx_msg_reg;
    assign TX_msg_valid_o = (state_reg == ARB_SEND);
    // grant_reg is still held during ACK, so it doubles as the ack one-hot.
    assign req_ack_o      = (state_reg == ARB_ACK) ? grant_reg : '0;
    assign busy_o         = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_ltsm_sb_tx_arbiter.sv
module tb_ltsm_sb_tx_arbiter;
    import SB_codex_pkg::*;

    logic            clk_100MHz = 1'b0;
    logic            reset      = 1'b0;
    logic [3:0]      req_valid  = '0;
    SB_msg_t [3:0]   req_msg    = '0;
    logic            tx_ack     = 1'b0;

    logic [3:0]      req_ack;
    logic [3:0]      grant;
    SB_msg_t         tx_msg;
    logic            tx_valid;
    logic            busy;
    logic            timeout_err;

    int              checks = 0;
    int              errors = 0;
    SB_msg_t         exp_msg_q[$];
    int              exp_idx_q[$];

    ltsm_sb_tx_arbiter #(
        .NUM_REQ     (4),
        .ACK_TIMEOUT (10)
    ) dut (
        .clk_100MHz         (clk_100MHz),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_msg_i          (req_msg),
        .req_ack_o          (req_ack),
        .grant_o            (grant),
        .TX_msg_o           (tx_msg),
        .TX_msg_valid_o     (tx_valid),
        .TX_msg_valid_ack_i (tx_ack),
        .busy_o             (busy),
        .timeout_err_o      (timeout_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic SB_msg_t mk_msg(input int idx, input int salt);
        SB_msg_t m;
        m.opcode      = 5'(salt);
        m.msg_code    = 8'(8'hA0 + idx);
        m.msg_subcode = 8'(salt * 3 + 1);
        m.msg_info    = 16'($urandom);
        return m;
    endfunction

    task automatic push(input int idx);
        exp_idx_q.push_back(idx);
        exp_msg_q.push_back(req_msg[idx]);
        $display("push: requester %0d msg=%0h", idx, req_msg[idx]);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_ack"}, req_ack, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Waits for the next grant, pops the expected winner and follows the
    // transfer through: d cycles of valid, transmitter ack, one-cycle req_ack.
    task automatic serve(input int lat, input int d, input logic [3:0] drop_mask, input bit meddle);
        int      n;
        int      idx;
        SB_msg_t m;
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        check("grant_latency", n, lat);
        idx = exp_idx_q.pop_front();
        m   = exp_msg_q.pop_front();
        check("grant_onehot", grant, 1 << idx);
        check("tx_msg", tx_msg, m);
        for (int i = 1; i < d; i++) begin
            tick();
            if (meddle && i == 1) begin
                req_msg[idx]   = ~req_msg[idx];
                req_valid[idx] = 1'b0;
            end
            check("valid_hold", tx_valid, 1);
            check("msg_hold", tx_msg, m);
            check("no_early_ack", req_ack, 0);
        end
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("valid_drop", tx_valid, 0);
        check("req_ack", req_ack, 1 << idx);
        check("busy_in_ack", busy, 1);
        req_valid = req_valid & ~drop_mask;
        tick();
        check("ack_one_cycle", req_ack, 0);
        check("grant_cleared", grant, 0);
        $display("served: requester %0d msg=%0h valid_cycles=%0d", idx, m, d);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        check("reset_msg", tx_msg, 0);
        check("reset_err", timeout_err, 0);
        reset = 1'b1;
        tick();

        // Spurious transmitter ack while idle
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check_idle("spurious");
        tick();
        check("spurious_busy_after", busy, 0);

        // Single request on requester 2, acked after 3 valid cycles
        req_msg[2] = mk_msg(2, 1);
        req_valid  = 4'b0100;
        push(2);
        serve(1, 3, 4'b0100, 1'b0);

        // Pointer now at 3: requester 3 beats 0, then 0 follows
        req_msg[0] = mk_msg(0, 2);
        req_msg[3] = mk_msg(3, 3);
        req_valid  = 4'b1001;
        push(3);
        push(0);
        serve(1, 1, 4'b1000, 1'b0);
        serve(1, 1, 4'b0001, 1'b0);

        // All four requesting continuously from reset: 0,1,2,3,0
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) req_msg[i] = mk_msg(i, 4 + i);
        req_valid = 4'hF;
        push(0); push(1); push(2); push(3); push(0);
        serve(1, 2, 4'b0000, 1'b0);
        serve(1, 2, 4'b0000, 1'b0);
        serve(1, 2, 4'b0000, 1'b0);
        serve(1, 2, 4'b0000, 1'b0);
        serve(1, 2, 4'b1111, 1'b0);

        // Requester 1 alters its message and drops valid after grant
        req_msg[1] = mk_msg(1, 9);
        req_valid  = 4'b0010;
        push(1);
        serve(1, 3, 4'b0010, 1'b1);

        // Reset during SEND drops the transfer; pointer restarts at 0
        req_msg[1] = mk_msg(1, 10);
        req_msg[2] = mk_msg(2, 11);
        req_valid  = 4'b0110;
        tick();
        check("pre_reset_valid", tx_valid, 1);
        check("pre_reset_grant", grant, 4'b0100);
        reset = 1'b0;
        #1;
        check_idle("reset_in_send");
        check("reset_in_send_msg", tx_msg, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_hold_ack", req_ack, 0);
            check("reset_hold_valid", tx_valid, 0);
        end
        reset = 1'b1;
        push(1);
        push(2);
        serve(1, 2, 4'b0010, 1'b0);
        serve(1, 2, 4'b0100, 1'b0);

`ifdef LTSM_SB_ARB_TIMEOUT_EN
        // No transmitter ack: abandon after 10 cycles, then serve next in order
        begin
            int n;
            req_msg[0] = mk_msg(0, 12);
            req_msg[3] = mk_msg(3, 13);
            req_valid  = 4'b1001;
            push(3);
            tick();
            check("to_grant", grant, 4'b1000);
            n = 0;
            while (tx_valid && n < 30) begin
                n++;
                check("to_no_ack", req_ack, 0);
                tick();
            end
            check("to_valid_cycles", n, 10);
            check("to_err", timeout_err, 1);
            check("to_valid_low", tx_valid, 0);
            check("to_grant_clr", grant, 0);
            void'(exp_idx_q.pop_front());
            void'(exp_msg_q.pop_front());
            $display("timeout: requester 3 abandoned after %0d valid cycles", n);
            req_valid[3] = 1'b0;
            push(0);
            serve(1, 2, 4'b0001, 1'b0);
            check("to_err_sticky", timeout_err, 1);
        end
`else
        // Without the timeout build a long stall is simply waited out
        req_msg[0] = mk_msg(0, 12);
        req_valid  = 4'b0001;
        push(0);
        serve(1, 15, 4'b0001, 1'b0);
        check("no_timeout_err", timeout_err, 0);
`endif

        check_idle("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
